// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the register-file write path.
package cpu_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;
    localparam logic [AW-1:0] REG_LAST = AW'(NREG - 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the priority pointer only moves when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant_c
);

    // last_grant=1 means requester 1 won most recently, so requester 0 is favoured next
    logic last_grant;

    always_comb begin
        grant_c = valid;
        if (valid == 2'b11) begin
            grant_c = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_c[1];
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: arbitrates writeback vs debug writes and sequences a clear of r1..r31.
module regfile_wr_arbiter
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          reg_we,
    output logic [AW-1:0] reg_W_addr,
    output logic [DW-1:0] wdata
);

    wr_state_t     state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          we_n, done_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    logic [1:0]    grant_c;
    logic          arb_en_c;

    // Requests are only eligible in ARB when no clear is being kicked off
    assign arb_en_c   = (state == ARB) && !clr_start;
    assign req0_ready = grant_c[0] && arb_en_c;
    assign req1_ready = grant_c[1] && arb_en_c;
    assign clr_busy   = (state != ARB);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .accept  (req0_ready || req1_ready),
        .grant_c (grant_c)
    );

    // Next state and next registered outputs
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = 1'b0;
        done_n  = 1'b0;
        addr_n  = reg_W_addr;
        data_n  = wdata;
        case (state)
            ARB: begin
                if (clr_start) begin
                    state_n = CLEAR;
                    cnt_n   = AW'(1);
                    we_n    = 1'b1;
                    addr_n  = AW'(1);
                    data_n  = '0;
                end else if (req0_ready) begin
                    we_n   = (req0_addr != REG_ZERO);
                    addr_n = req0_addr;
                    data_n = req0_data;
                end else if (req1_ready) begin
                    we_n   = (req1_addr != REG_ZERO);
                    addr_n = req1_addr;
                    data_n = req1_data;
                end
            end
            CLEAR: begin
                if (cnt == REG_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt + AW'(1);
                    we_n   = 1'b1;
                    addr_n = cnt + AW'(1);
                    data_n = '0;
                end
            end
            DONE: begin
                state_n = ARB;
                cnt_n   = '0;
            end
            default: begin
                state_n = ARB;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            cnt        <= '0;
            reg_we     <= 1'b0;
            reg_W_addr <= '0;
            wdata      <= '0;
            clr_done   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            reg_we     <= we_n;
            reg_W_addr <= addr_n;
            wdata      <= data_n;
            clr_done   <= done_n;
        end
    end

endmodule
